rv_regdump_checker: RTL
=======================

// Module: rv_regdump_checker
// PURPOSE
//  Synthesizable end-of-test controller for the rv32i_top core. It watches the fetch PC and writeback
//  port, and detects halt or timeout. It then reads every architectural register through a debug read
//  port, streams each value out over a valid/ready handshake, and compares it against a preloaded table.
//  It sits beside rv32i_top inside the simulation/FPGA harness and produces done/pass flags.
// PARAMETERS
//  XLEN           32   data/PC width
//  NREGS          32   registers dumped/checked (idx 0..NREGS-1); AW = $clog2(NREGS)
//  TIMEOUT_CYCLES 70   RUN cycles before forced stop (70 x 10 ns = 700 ns)
//  HALT_REPEAT    4    consecutive cycles with unchanged pc_if that count as halt (>=2)
// PORTS
//  clk            in   1        clock, all logic rising-edge
//  reset          in   1        synchronous, active-high
//  start          in   1        begin run (sampled in IDLE/DONE only)
//  pc_if          in   XLEN     core fetch PC
//  wb_en          in   1        core register write strobe
//  wb_addr        in   AW       core write destination
//  exp_wr_en      in   1        load expected-value entry (accepted in IDLE/DONE only)
//  exp_wr_addr    in   AW       expected entry index
//  exp_wr_data    in   XLEN     expected value; sets exp_valid[addr]
//  rf_rd_addr     out  AW       debug read address to register file
//  rf_rd_data     in   XLEN     debug read data, valid 1 cycle after rf_rd_addr
//  dump_valid     out  1        dump beat valid
//  dump_ready     in   1        consumer accepts beat
//  dump_idx       out  AW       register index of beat
//  dump_data      out  XLEN     register value of beat
//  dump_mismatch  out  1        beat value != expected (only if exp_valid[idx])
//  done           out  1        all NREGS beats accepted
//  pass           out  1        done & !timed_out & mismatch_count==0
//  timed_out      out  1        RUN ended by timeout
//  mismatch_count out  AW+1     mismatching registers
//  cycle_count    out  32       RUN cycles elapsed, saturating
//  wb_count       out  32       wb_en cycles with wb_addr!=0 during RUN, saturating
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; exp_valid[] cleared (table data not cleared).
//  - IDLE: start -> RUN, clearing cycle_count, wb_count, mismatch_count, timed_out, halt counter.
//  - RUN: cycle_count++ each cycle. Halt counter ++ when pc_if==previous pc_if, else 0.
//    Counter reaching HALT_REPEAT-1 -> READ. Else cycle_count reaching TIMEOUT_CYCLES-1 -> READ with timed_out=1.
//    Halt and timeout in same cycle: halt wins, timed_out=0. Enter READ with idx=0.
//  - READ (1 cycle): rf_rd_addr=idx. Next edge: dump_data<=rf_rd_data, dump_idx<=idx, dump_valid<=1.
//    dump_mismatch<=exp_valid[idx] & (rf_rd_data!=exp[idx]); mismatch_count increments if set; -> DUMP.
//  - DUMP: dump_* held stable while dump_valid & !dump_ready. On handshake: dump_valid<=0.
//    idx==NREGS-1 -> DONE, else idx++ -> READ. Min 2 cycles per register; no bubble-free mode.
//  - DONE: done=1, pass valid, all counters frozen. start -> RUN (same clears as IDLE; table retained).
//  - rf_rd_addr = 0 outside READ. start in RUN/READ/DUMP is ignored; exp_wr_en outside IDLE/DONE is ignored.
//  - Reset mid-run/mid-dump: immediate return to IDLE, dump_valid drops next edge, no partial done.
//  - Counters saturate at all-ones; no wrap.
// TESTING
//  1. Table x1=5,x2=7 loaded; core writes x1=5,x2=7, PC loops at 0x40 -> 32 beats idx 0..31, done=1, pass=1, mismatch_count=0.
//  2. Same but x2 expected 8 -> beat idx2 dump_mismatch=1, mismatch_count=1, pass=0.
//  3. PC never repeats -> READ entered at cycle_count=69, timed_out=1, pass=0 even with zero mismatches.
//  4. dump_ready low 5 cycles on beat 3 -> dump_idx=3 and dump_data unchanged throughout, no beat lost/duplicated.
//  5. reset asserted during beat 10 -> next cycle IDLE, dump_valid=0, done=0; exp_valid cleared, so next run passes with 0 mismatches.
//  6. Halt on cycle 69 exactly (halt & timeout coincide) -> timed_out=0; exp_wr_en during RUN -> table unchanged.

Source files
------------

// File: rtl/rv_regdump_checker_if.sv
// Bundle between rv_regdump_checker and its harness: core monitor, expected-table load,
// register-file debug read, dump stream and end-of-test status.
interface rv_regdump_checker_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int AW = $clog2(NREGS);

    logic            start;
    logic [XLEN-1:0] pc_if;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic            exp_wr_en;
    logic [AW-1:0]   exp_wr_addr;
    logic [XLEN-1:0] exp_wr_data;
    logic [AW-1:0]   rf_rd_addr;
    logic [XLEN-1:0] rf_rd_data;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;
    logic            dump_mismatch;
    logic            done;
    logic            pass;
    logic            timed_out;
    logic [AW:0]     mismatch_count;
    logic [31:0]     cycle_count;
    logic [31:0]     wb_count;

    // Harness side: drives the core observation, table load, RF data and stream back-pressure.
    modport master (
        output start, pc_if, wb_en, wb_addr, exp_wr_en, exp_wr_addr, exp_wr_data,
               rf_rd_data, dump_ready,
        input  rf_rd_addr, dump_valid, dump_idx, dump_data, dump_mismatch,
               done, pass, timed_out, mismatch_count, cycle_count, wb_count
    );

    // Checker side.
    modport slave (
        input  start, pc_if, wb_en, wb_addr, exp_wr_en, exp_wr_addr, exp_wr_data,
               rf_rd_data, dump_ready,
        output rf_rd_addr, dump_valid, dump_idx, dump_data, dump_mismatch,
               done, pass, timed_out, mismatch_count, cycle_count, wb_count
    );
endinterface

// File: rtl/rv_regdump_checker.sv
// End-of-test controller: detects halt/timeout of the core, then dumps every register over a
// valid/ready stream while comparing against a preloaded expected-value table.
module rv_regdump_checker #(
    parameter int XLEN           = 32,
    parameter int NREGS          = 32,
    parameter int TIMEOUT_CYCLES = 70,
    parameter int HALT_REPEAT    = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    rv_regdump_checker_if.slave  bus
);
    localparam int AW = $clog2(NREGS);
    localparam int HW = $clog2(HALT_REPEAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_READ,
        S_DUMP,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [31:0]     cyc_q, cyc_d;
    logic [31:0]     wbc_q, wbc_d;
    logic [AW:0]     mis_q, mis_d;
    logic            to_q, to_d;
    logic [HW-1:0]   halt_q, halt_d;
    logic [XLEN-1:0] pc_prev_q;
    logic            dv_q, dv_d;
    logic [AW-1:0]   didx_q, didx_d;
    logic [XLEN-1:0] ddata_q, ddata_d;
    logic            dmis_q, dmis_d;
    logic [NREGS-1:0] expv_q, expv_d;
    logic [XLEN-1:0] exp_mem [NREGS];

    logic            table_open;
    logic [31:0]     cyc_inc;
    logic [31:0]     wbc_inc;
    logic [AW:0]     mis_inc;
    logic [HW-1:0]   halt_nxt;
    logic            rd_mis;

    // The table and the start request are only honoured while the core is not being observed.
    assign table_open = (state_q == S_IDLE) || (state_q == S_DONE);
    assign cyc_inc    = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
    assign wbc_inc    = (&wbc_q) ? wbc_q : wbc_q + 32'd1;
    assign mis_inc    = (&mis_q) ? mis_q : mis_q + 1'b1;
    assign halt_nxt   = (bus.pc_if == pc_prev_q) ? halt_q + 1'b1 : '0;
    assign rd_mis     = expv_q[idx_q] && (bus.rf_rd_data != exp_mem[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        wbc_d   = wbc_q;
        mis_d   = mis_q;
        to_d    = to_q;
        halt_d  = halt_q;
        dv_d    = dv_q;
        didx_d  = didx_q;
        ddata_d = ddata_q;
        dmis_d  = dmis_q;
        expv_d  = expv_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.exp_wr_en) expv_d[bus.exp_wr_addr] = 1'b1;
                if (bus.start) begin
                    state_d = S_RUN;
                    cyc_d   = '0;
                    wbc_d   = '0;
                    mis_d   = '0;
                    to_d    = 1'b0;
                    halt_d  = '0;
                end
            end
            S_RUN: begin
                cyc_d  = cyc_inc;
                halt_d = halt_nxt;
                if (bus.wb_en && (bus.wb_addr != '0)) wbc_d = wbc_inc;
                // Halt is checked first so a coincident timeout is not reported.
                if (halt_nxt == HW'(HALT_REPEAT - 1)) begin
                    state_d = S_READ;
                    idx_d   = '0;
                end else if (cyc_inc == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_READ;
                    idx_d   = '0;
                    to_d    = 1'b1;
                end
            end
            S_READ: begin
                dv_d    = 1'b1;
                didx_d  = idx_q;
                ddata_d = bus.rf_rd_data;
                dmis_d  = rd_mis;
                if (rd_mis) mis_d = mis_inc;
                state_d = S_DUMP;
            end
            S_DUMP: begin
                if (bus.dump_ready) begin
                    dv_d = 1'b0;
                    if (idx_q == AW'(NREGS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cyc_q     <= '0;
            wbc_q     <= '0;
            mis_q     <= '0;
            to_q      <= 1'b0;
            halt_q    <= '0;
            pc_prev_q <= '0;
            dv_q      <= 1'b0;
            didx_q    <= '0;
            ddata_q   <= '0;
            dmis_q    <= 1'b0;
            expv_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cyc_q     <= cyc_d;
            wbc_q     <= wbc_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
            halt_q    <= halt_d;
            pc_prev_q <= bus.pc_if;
            dv_q      <= dv_d;
            didx_q    <= didx_d;
            ddata_q   <= ddata_d;
            dmis_q    <= dmis_d;
            expv_q    <= expv_d;
        end
    end

    // Table contents survive reset; only the per-entry valid bits are cleared.
    always_ff @(posedge clk_i) begin
        if (!reset_i && table_open && bus.exp_wr_en) exp_mem[bus.exp_wr_addr] <= bus.exp_wr_data;
    end

    assign bus.rf_rd_addr     = (state_q == S_READ) ? idx_q : '0;
    assign bus.dump_valid     = dv_q;
    assign bus.dump_idx       = didx_q;
    assign bus.dump_data      = ddata_q;
    assign bus.dump_mismatch  = dmis_q;
    assign bus.done           = (state_q == S_DONE);
    assign bus.pass           = (state_q == S_DONE) && !to_q && (mis_q == '0);
    assign bus.timed_out      = to_q;
    assign bus.mismatch_count = mis_q;
    assign bus.cycle_count    = cyc_q;
    assign bus.wb_count       = wbc_q;
endmodule
